// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full-adder cell: y0 is the sum bit, y1 is the majority carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y0,
  output logic y1
);

  assign y0 = a ^ b ^ c;
  assign y1 = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder that processes one bit per clock, LSB first,
// with a start/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] s_sr_next;

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .c  (carry_q),
    .y0 (fa_sum),
    .y1 (fa_carry)
  );

  assign s_sr_next = {fa_sum, s_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = op_a;
          b_sr_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
          s_sr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_sr_next;
        carry_d = fa_carry;
        // Counter stops at the last bit so it never wraps for power-of-two widths.
        if (cnt_q == LAST_BIT) begin
          sum_d   = s_sr_next;
          cout_d  = fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard-driven bench for serial_adder: an 8-bit instance for handshake,
// hazard and back-to-back scenarios, plus a 3-bit instance swept exhaustively.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] op_a, op_b;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  logic       start3;
  logic [2:0] a3, b3;
  logic       cin3;
  logic       busy3, done3;
  logic [2:0] sum3;
  logic       cout3;

  int checks   = 0;
  int failures = 0;

  logic [8:0] sb[$];
  logic [3:0] sb3[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .op_a(a3), .op_b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on the 8-bit instance; the accepting edge is consumed here.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(9'(a) + 9'(b) + 9'(c));
  endtask

  task automatic wait_done(input bit use3, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      cycles++;
      if (use3 ? done3 : done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({busy, done, cout, sum} !== 11'd0) begin
        failures++;
        $display("[TB] FAIL reset_idle cycle %0d: busy=%b done=%b cout=%b sum=%h, want all 0",
                 i, busy, done, cout, sum);
      end
    end
  endtask

  task automatic test_basic_latency();
    logic [8:0] exp;
    launch(8'h64, 8'h1B, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (busy !== (k < 8) || done !== (k == 8)) begin
        failures++;
        $display("[TB] FAIL latency k=%0d: busy=%b done=%b, want busy=%b done=%b",
                 k, busy, done, (k < 8), (k == 8));
      end
    end
    exp = sb.pop_front();
    checks++;
    if ({cout, sum} !== exp) begin
      failures++;
      $display("[TB] FAIL basic_sum: got %h, want %h", {cout, sum}, exp);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_pulse_width: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_carry();
    logic [8:0] exp;
    int cycles;
    bit seen;
    logic [7:0] av[2] = '{8'hFF, 8'hA5};
    logic [7:0] bv[2] = '{8'h01, 8'h5A};
    logic       cv[2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      launch(av[i], bv[i], cv[i]);
      wait_done(1'b0, cycles, seen);
      exp = sb.pop_front();
      checks++;
      if (!seen || cycles != 8 || {cout, sum} !== exp) begin
        failures++;
        $display("[TB] FAIL carry_%0d: seen=%b cycles=%0d got %h, want cycles=8 result %h",
                 i, seen, cycles, {cout, sum}, exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [8:0] exp;
    launch(8'h10, 8'h20, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        op_a = 8'h01; op_b = 8'h01; start = 1'b1;
      end else if (k == 4) begin
        start = 1'b0; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
      end
      tick();
      checks++;
      if (done !== (k == 8)) begin
        failures++;
        $display("[TB] FAIL ignored_start_done k=%0d: done=%b, want %b", k, done, (k == 8));
      end
    end
    exp = sb.pop_front();
    checks++;
    if ({cout, sum} !== exp) begin
      failures++;
      $display("[TB] FAIL ignored_start_sum: got %h, want %h", {cout, sum}, exp);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignored_start_extra_op: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    launch(8'h3C, 8'hC3, 1'b1);
    for (int k = 1; k <= 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid: busy=%b done=%b cout=%b sum=%h, want all 0",
               busy, done, cout, sum);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy || sum !== 8'h00 || cout !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("[TB] FAIL reset_mid_quiet: activity after reset (done=%b sum=%h), want none",
               done, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av[3] = '{8'h12, 8'hF0, 8'h7F};
    logic [7:0] bv[3] = '{8'h34, 8'h1F, 8'h80};
    logic       cv[3] = '{1'b1, 1'b0, 1'b1};
    logic [8:0] exp, prev;
    int  pulses = 0, idx = 1, cyc = 0;
    bit  have_prev = 1'b0;
    op_a = av[0]; op_b = bv[0]; cin = cv[0]; start = 1'b1;
    tick();
    sb.push_back(9'(av[0]) + 9'(bv[0]) + 9'(cv[0]));
    prev = '0;
    for (int g = 0; g < 40 && pulses < 3; g++) begin
      tick();
      cyc++;
      if (done) begin
        exp = sb.pop_front();
        checks++;
        if (cyc != (pulses == 0 ? 8 : 9) || {cout, sum} !== exp) begin
          failures++;
          $display("[TB] FAIL b2b_pulse_%0d: interval=%0d got %h, want interval=%0d result %h",
                   pulses, cyc, {cout, sum}, (pulses == 0 ? 8 : 9), exp);
        end
        pulses++;
        prev = exp;
        have_prev = 1'b1;
        cyc = 0;
        if (idx < 3) begin
          op_a = av[idx]; op_b = bv[idx]; cin = cv[idx];
          sb.push_back(9'(av[idx]) + 9'(bv[idx]) + 9'(cv[idx]));
          idx++;
        end else begin
          start = 1'b0;
        end
      end else if (have_prev) begin
        checks++;
        if ({cout, sum} !== prev) begin
          failures++;
          $display("[TB] FAIL b2b_hold: got %h, want %h", {cout, sum}, prev);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("[TB] FAIL b2b_timeout: pulses=%0d, want 3", pulses);
    end
  endtask

  task automatic test_width3_sweep();
    logic [3:0] exp;
    int cycles;
    bit seen;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          a3 = 3'(a); b3 = 3'(b); cin3 = 1'(c); start3 = 1'b1;
          tick();
          start3 = 1'b0;
          sb3.push_back(4'(a) + 4'(b) + 4'(c));
          wait_done(1'b1, cycles, seen);
          exp = sb3.pop_front();
          checks++;
          if (!seen || cycles != 3 || busy3 !== 1'b0 || {cout3, sum3} !== exp) begin
            failures++;
            $display("[TB] FAIL w3 a=%0d b=%0d c=%0d: seen=%b cycles=%0d got %h, want cycles=3 result %h",
                     a, b, c, seen, cycles, {cout3, sum3}, exp);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_carry();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_width3_sweep();
    checks++;
    if (sb.size() != 0 || sb3.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d/%0d entries left, want 0/0", sb.size(), sb3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
